// File: rtl/led_cntr_pkg.sv
// led_cntr_pkg: shared types, register map and response codes for the
// multi-channel AXI4-Lite LED controller (led_cntr_axil_mch).
package led_cntr_pkg;

  typedef enum logic [1:0] {
    LED_OFF   = 2'd0,
    LED_ON    = 2'd1,
    LED_BLINK = 2'd2,
    LED_PWM   = 2'd3
  } led_mode_e;

  localparam logic [6:0] OFF_CTRL     = 7'h00;
  localparam logic [6:0] OFF_PRESCALE = 7'h04;
  localparam logic [6:0] OFF_STATUS   = 7'h08;
  localparam logic [6:0] OFF_ID       = 7'h0C;
  localparam logic [6:0] OFF_CH0      = 7'h10;

  localparam logic [31:0] ID_BASE = 32'h4C43_0000;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  function automatic logic [31:0] id_word(input int unsigned n);
    return ID_BASE | {24'd0, n[7:0]};
  endfunction

  function automatic logic [31:0] strb_merge(
    input logic [31:0] old_v,
    input logic [31:0] new_v,
    input logic [3:0]  strb
  );
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++)
      if (strb[b]) r[8*b +: 8] = new_v[8*b +: 8];
    return r;
  endfunction

endpackage

// File: rtl/led_cntr_channel.sv
// led_cntr_channel: one LED channel -- blink counter, blink phase
// and the OFF/ON/BLINK/PWM output mux.
module led_cntr_channel
  import led_cntr_pkg::*;
#(
  parameter int PWM_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             tick_i,
  input  led_mode_e        mode_i,
  input  logic [PWM_W-1:0] duty_i,
  input  logic [PWM_W-1:0] pwm_cnt_i,
  input  logic [15:0]      half_i,
  output logic             led_o
);

  logic [15:0] cnt_q;
  logic        phase_q;

  // Blink counter: wraps at half-period-1 and flips the phase.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else if (clr_i) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else if (tick_i) begin
      if (half_i == 16'd0) begin
        cnt_q   <= '0;
        phase_q <= 1'b0;
      end else if (cnt_q >= half_i - 16'd1) begin
        cnt_q   <= '0;
        phase_q <= ~phase_q;
      end else begin
        cnt_q <= cnt_q + 16'd1;
      end
    end
  end

  // Mode mux selecting the logical LED level.
  always_comb begin
    led_o = 1'b0;
    unique case (mode_i)
      LED_OFF:   led_o = 1'b0;
      LED_ON:    led_o = 1'b1;
      LED_BLINK: led_o = phase_q;
      LED_PWM:   led_o = (pwm_cnt_i < duty_i);
      default:   led_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/led_cntr_axil_mch.sv
// led_cntr_axil_mch: AXI4-Lite slave, register file, prescaler and PWM
// counter driving NUM_CH LED channels. Option: LED_CNTR_ACTIVE_LOW_EN.
module led_cntr_axil_mch
  import led_cntr_pkg::*;
#(
  parameter int NUM_CH             = 8,
  parameter int PWM_W              = 8,
  parameter int PRE_W              = 16,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 7
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [NUM_CH-1:0]               led_o
);

`ifdef LED_CNTR_ACTIVE_LOW_EN
  localparam logic [NUM_CH-1:0] LED_INV = '1;
`else
  localparam logic [NUM_CH-1:0] LED_INV = '0;
`endif

  localparam logic [4:0] IX_CTRL = OFF_CTRL[6:2];
  localparam logic [4:0] IX_PRE  = OFF_PRESCALE[6:2];
  localparam logic [4:0] IX_STAT = OFF_STATUS[6:2];
  localparam logic [4:0] IX_ID   = OFF_ID[6:2];
  localparam logic [4:0] IX_CH0  = OFF_CH0[6:2];

  localparam logic [31:0] DUTY_M  = ((32'd1 << PWM_W) - 32'd1) << 8;
  localparam logic [31:0] CH_MASK = 32'hFFFF_0003 | DUTY_M;
  localparam logic [31:0] ID_VAL  = id_word(NUM_CH);

  typedef enum logic [1:0] {WS_IDLE, WS_ACK, WS_RESP} wstate_e;
  typedef enum logic [1:0] {RS_IDLE, RS_ACK, RS_DATA} rstate_e;

  wstate_e ws_q;
  rstate_e rs_q;

  logic              en_q;
  logic [PRE_W-1:0]  pre_q;
  logic [31:0]       ch_q [NUM_CH];
  logic [PRE_W-1:0]  pre_cnt_q;
  logic [PWM_W-1:0]  pwm_q;
  logic [NUM_CH-1:0] led_q;
  logic [NUM_CH-1:0] out_q;

  logic [4:0]        aw_ix;
  logic [4:0]        ar_ix;
  logic [NUM_CH-1:0] aw_ch;
  logic [NUM_CH-1:0] ar_ch;
  logic [NUM_CH-1:0] ch_wr;
  logic [NUM_CH-1:0] led_log;
  logic [NUM_CH-1:0] led_d;
  logic              wr_hs;
  logic              rd_hs;
  logic              wr_ok;
  logic              rd_ok;
  logic [31:0]       rd_val;
  logic              clr;
  logic              tick;

  logic unused_ok;
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                       S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  assign aw_ix = S_AXI_AWADDR[6:2];
  assign ar_ix = S_AXI_ARADDR[6:2];
  assign wr_hs = (ws_q == WS_ACK) && S_AXI_AWVALID && S_AXI_WVALID;
  assign rd_hs = (rs_q == RS_ACK) && S_AXI_ARVALID;

  // Channel address decode for both write and read ports.
  always_comb begin
    aw_ch = '0;
    ar_ch = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      aw_ch[k] = (aw_ix == IX_CH0 + 5'(k));
      ar_ch[k] = (ar_ix == IX_CH0 + 5'(k));
    end
  end

  assign wr_ok = (aw_ix == IX_CTRL) || (aw_ix == IX_PRE) || (|aw_ch);
  assign ch_wr = wr_hs ? aw_ch : '0;
  assign clr   = wr_hs && (aw_ix == IX_CTRL) &&
                 S_AXI_WSTRB[0] && S_AXI_WDATA[1];

  // Read mux; unmapped offsets give zero and an error.
  always_comb begin
    rd_val = '0;
    rd_ok  = 1'b1;
    unique case (1'b1)
      (ar_ix == IX_CTRL): rd_val = {31'd0, en_q};
      (ar_ix == IX_PRE):  rd_val = 32'(pre_q);
      (ar_ix == IX_STAT): rd_val = 32'(led_q);
      (ar_ix == IX_ID):   rd_val = ID_VAL;
      (|ar_ch): begin
        for (int k = 0; k < NUM_CH; k++)
          if (ar_ch[k]) rd_val = ch_q[k];
      end
      default: rd_ok = 1'b0;
    endcase
  end

  // Write channel FSM: ready pulse, then response until BREADY.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      ws_q          <= WS_IDLE;
      S_AXI_AWREADY <= 1'b0;
      S_AXI_WREADY  <= 1'b0;
      S_AXI_BVALID  <= 1'b0;
      S_AXI_BRESP   <= RESP_OKAY;
    end else begin
      unique case (ws_q)
        WS_IDLE: begin
          if (S_AXI_AWVALID && S_AXI_WVALID) begin
            ws_q          <= WS_ACK;
            S_AXI_AWREADY <= 1'b1;
            S_AXI_WREADY  <= 1'b1;
          end
        end
        WS_ACK: begin
          S_AXI_AWREADY <= 1'b0;
          S_AXI_WREADY  <= 1'b0;
          if (S_AXI_AWVALID && S_AXI_WVALID) begin
            ws_q         <= WS_RESP;
            S_AXI_BVALID <= 1'b1;
            S_AXI_BRESP  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
          end else begin
            ws_q <= WS_IDLE;
          end
        end
        WS_RESP: begin
          if (S_AXI_BREADY) begin
            ws_q         <= WS_IDLE;
            S_AXI_BVALID <= 1'b0;
          end
        end
        default: ws_q <= WS_IDLE;
      endcase
    end
  end

  // Read channel FSM: ready pulse, then data held until RREADY.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rs_q          <= RS_IDLE;
      S_AXI_ARREADY <= 1'b0;
      S_AXI_RVALID  <= 1'b0;
      S_AXI_RDATA   <= '0;
      S_AXI_RRESP   <= RESP_OKAY;
    end else begin
      unique case (rs_q)
        RS_IDLE: begin
          if (S_AXI_ARVALID) begin
            rs_q          <= RS_ACK;
            S_AXI_ARREADY <= 1'b1;
          end
        end
        RS_ACK: begin
          S_AXI_ARREADY <= 1'b0;
          if (rd_hs) begin
            rs_q         <= RS_DATA;
            S_AXI_RVALID <= 1'b1;
            S_AXI_RDATA  <= rd_val;
            S_AXI_RRESP  <= rd_ok ? RESP_OKAY : RESP_SLVERR;
          end else begin
            rs_q <= RS_IDLE;
          end
        end
        RS_DATA: begin
          if (S_AXI_RREADY) begin
            rs_q         <= RS_IDLE;
            S_AXI_RVALID <= 1'b0;
          end
        end
        default: rs_q <= RS_IDLE;
      endcase
    end
  end

  // Register file, updated on the write handshake edge.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      en_q  <= 1'b0;
      pre_q <= '0;
      for (int k = 0; k < NUM_CH; k++) ch_q[k] <= '0;
    end else if (wr_hs) begin
      if (aw_ix == IX_CTRL && S_AXI_WSTRB[0])
        en_q <= S_AXI_WDATA[0];
      if (aw_ix == IX_PRE)
        pre_q <= PRE_W'(strb_merge(32'(pre_q),
                                   S_AXI_WDATA, S_AXI_WSTRB));
      for (int k = 0; k < NUM_CH; k++)
        if (aw_ch[k])
          ch_q[k] <= strb_merge(ch_q[k], S_AXI_WDATA,
                                S_AXI_WSTRB) & CH_MASK;
    end
  end

  assign tick = en_q && (pre_cnt_q >= pre_q);

  // Prescaler: counts 0..PRESCALE, idles at 0 while disabled.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN)   pre_cnt_q <= '0;
    else if (!en_q) pre_cnt_q <= '0;
    else if (tick)  pre_cnt_q <= '0;
    else            pre_cnt_q <= pre_cnt_q + PRE_W'(1);
  end

  // Shared PWM counter; clear wins over tick.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN)          pwm_q <= '0;
    else if (!en_q || clr) pwm_q <= '0;
    else if (tick)         pwm_q <= pwm_q + PWM_W'(1);
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    led_cntr_channel #(.PWM_W(PWM_W)) u_ch (
      .clk_i     (ACLK),
      .rst_ni    (ARESETN),
      .clr_i     (clr | ch_wr[g] | ~en_q),
      .tick_i    (tick),
      .mode_i    (led_mode_e'(ch_q[g][1:0])),
      .duty_i    (ch_q[g][8 +: PWM_W]),
      .pwm_cnt_i (pwm_q),
      .half_i    (ch_q[g][31:16]),
      .led_o     (led_log[g])
    );
  end

  assign led_d = en_q ? led_log : '0;

  // Output register plus logical copy for STATUS.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      led_q <= '0;
      out_q <= LED_INV;
    end else begin
      led_q <= led_d;
      out_q <= led_d ^ LED_INV;
    end
  end

  assign led_o = out_q;

endmodule

// File: tb/tb_led_cntr_axil_mch.sv
// tb_led_cntr_axil_mch: table-driven register vectors plus
// hand sequences for latency, blink, PWM and back-pressure.
module tb_led_cntr_axil_mch;

  logic        ACLK = 1'b0;
  logic        ARESETN = 1'b0;
  logic [6:0]  S_AXI_AWADDR = '0;
  logic [2:0]  S_AXI_AWPROT = '0;
  logic        S_AXI_AWVALID = 1'b0;
  logic        S_AXI_AWREADY;
  logic [31:0] S_AXI_WDATA = '0;
  logic [3:0]  S_AXI_WSTRB = '0;
  logic        S_AXI_WVALID = 1'b0;
  logic        S_AXI_WREADY;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_BVALID;
  logic        S_AXI_BREADY = 1'b1;
  logic [6:0]  S_AXI_ARADDR = '0;
  logic [2:0]  S_AXI_ARPROT = '0;
  logic        S_AXI_ARVALID = 1'b0;
  logic        S_AXI_ARREADY;
  logic [31:0] S_AXI_RDATA;
  logic [1:0]  S_AXI_RRESP;
  logic        S_AXI_RVALID;
  logic        S_AXI_RREADY = 1'b1;
  logic [7:0]  led_o;

  led_cntr_axil_mch dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
    .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .led_o(led_o)
  );

  always #5 ACLK = ~ACLK;

  localparam logic [1:0] OK  = 2'b00;
  localparam logic [1:0] ERR = 2'b10;

  typedef struct {
    logic [31:0] exp_d;
    logic [1:0]  exp_r;
    string       tag;
  } rexp_t;

  typedef struct {
    logic [1:0] exp_r;
    string      tag;
  } bexp_t;

  typedef struct {
    bit          wr;
    logic [6:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp_d;
    logic [1:0]  exp_r;
  } vec_t;

  rexp_t rq[$];
  bexp_t bq[$];

  int checks = 0;
  int errors = 0;
  logic [7:0] led_snap;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h required 0x%08h", nm, act, exp);
    end
  endtask

  task automatic tmo(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: timeout, required a response within bound", nm);
  endtask

  // Scoreboard: pop expected responses as the DUT completes them.
  always @(negedge ACLK) begin
    rexp_t re;
    bexp_t be;
    if (ARESETN && S_AXI_RVALID && S_AXI_RREADY) begin
      if (rq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_r: got R beat, required none");
      end else begin
        re = rq.pop_front();
        chk({re.tag, "_rdata"}, S_AXI_RDATA, re.exp_d);
        chk({re.tag, "_rresp"}, 32'(S_AXI_RRESP), 32'(re.exp_r));
      end
    end
    if (ARESETN && S_AXI_BVALID && S_AXI_BREADY) begin
      if (bq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_b: got B beat, required none");
      end else begin
        be = bq.pop_front();
        chk({be.tag, "_bresp"}, 32'(S_AXI_BRESP), 32'(be.exp_r));
      end
    end
  end

  task automatic wait_aw(input string nm);
    int n;
    n = 0;
    do begin @(negedge ACLK); n++; end
    while (!S_AXI_AWREADY && n < 50);
    if (!S_AXI_AWREADY) tmo({nm, "_awready"});
  endtask

  task automatic axi_write(input logic [6:0] a, input logic [31:0] d,
                           input logic [3:0] s, input logic [1:0] r,
                           input string nm);
    int n;
    bq.push_back('{exp_r: r, tag: nm});
    S_AXI_AWADDR  = a;
    S_AXI_WDATA   = d;
    S_AXI_WSTRB   = s;
    S_AXI_AWVALID = 1'b1;
    S_AXI_WVALID  = 1'b1;
    wait_aw(nm);
    @(posedge ACLK); #1;
    S_AXI_AWVALID = 1'b0;
    S_AXI_WVALID  = 1'b0;
    n = 0;
    do begin @(negedge ACLK); n++; end
    while (!S_AXI_BVALID && n < 50);
    led_snap = led_o;
    if (!S_AXI_BVALID) tmo({nm, "_bvalid"});
    @(posedge ACLK); #1;
  endtask

  task automatic axi_read(input logic [6:0] a, input logic [31:0] d,
                          input logic [1:0] r, input string nm);
    int n;
    rq.push_back('{exp_d: d, exp_r: r, tag: nm});
    S_AXI_ARADDR  = a;
    S_AXI_ARVALID = 1'b1;
    n = 0;
    do begin @(negedge ACLK); n++; end
    while (!S_AXI_ARREADY && n < 50);
    if (!S_AXI_ARREADY) tmo({nm, "_arready"});
    @(posedge ACLK); #1;
    S_AXI_ARVALID = 1'b0;
    n = 0;
    do begin @(negedge ACLK); n++; end
    while (!S_AXI_RVALID && n < 50);
    if (!S_AXI_RVALID) tmo({nm, "_rvalid"});
    @(posedge ACLK); #1;
  endtask

  task automatic wait_empty(input string nm);
    int n;
    n = 0;
    while ((rq.size() != 0 || bq.size() != 0) && n < 50) begin
      @(negedge ACLK);
      n++;
    end
    if (rq.size() != 0 || bq.size() != 0) tmo({nm, "_drain"});
    @(posedge ACLK); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t  tbl[27];
    int    duties[4];
    logic  prev;
    int    run, tog, bad, hi, seen;

    tbl[0]  = '{1'b0, 7'h0C, 32'h0, 4'h0, 32'h4C43_0008, OK};
    tbl[1]  = '{1'b0, 7'h08, 32'h0, 4'h0, 32'h0, OK};
    tbl[2]  = '{1'b0, 7'h00, 32'h0, 4'h0, 32'h0, OK};
    tbl[3]  = '{1'b1, 7'h00, 32'h1, 4'hF, 32'h0, OK};
    tbl[4]  = '{1'b1, 7'h10, 32'h1, 4'hF, 32'h0, OK};
    tbl[5]  = '{1'b1, 7'h14, 32'h0, 4'hF, 32'h0, OK};
    tbl[6]  = '{1'b0, 7'h00, 32'h0, 4'h0, 32'h1, OK};
    tbl[7]  = '{1'b0, 7'h10, 32'h0, 4'h0, 32'h1, OK};
    tbl[8]  = '{1'b0, 7'h08, 32'h0, 4'h0, 32'h1, OK};
    tbl[9]  = '{1'b1, 7'h08, 32'hFFFF_FFFF, 4'hF, 32'h0, ERR};
    tbl[10] = '{1'b0, 7'h08, 32'h0, 4'h0, 32'h1, OK};
    tbl[11] = '{1'b1, 7'h60, 32'hFFFF_FFFF, 4'hF, 32'h0, ERR};
    tbl[12] = '{1'b0, 7'h60, 32'h0, 4'h0, 32'h0, ERR};
    tbl[13] = '{1'b1, 7'h0C, 32'h0, 4'hF, 32'h0, ERR};
    tbl[14] = '{1'b0, 7'h0C, 32'h0, 4'h0, 32'h4C43_0008, OK};
    tbl[15] = '{1'b0, 7'h30, 32'h0, 4'h0, 32'h0, ERR};
    tbl[16] = '{1'b1, 7'h04, 32'h0001_2345, 4'hF, 32'h0, OK};
    tbl[17] = '{1'b0, 7'h04, 32'h0, 4'h0, 32'h2345, OK};
    tbl[18] = '{1'b1, 7'h04, 32'h0, 4'hF, 32'h0, OK};
    tbl[19] = '{1'b1, 7'h14, 32'hFFFF_FFFF, 4'hF, 32'h0, OK};
    tbl[20] = '{1'b0, 7'h14, 32'h0, 4'h0, 32'hFFFF_FF03, OK};
    tbl[21] = '{1'b1, 7'h14, 32'h0, 4'hF, 32'h0, OK};
    tbl[22] = '{1'b1, 7'h10, 32'h0000_AB00, 4'h2, 32'h0, OK};
    tbl[23] = '{1'b0, 7'h10, 32'h0, 4'h0, 32'h0000_AB01, OK};
    tbl[24] = '{1'b1, 7'h10, 32'h1, 4'hF, 32'h0, OK};
    tbl[25] = '{1'b0, 7'h4C, 32'h0, 4'h0, 32'h0, ERR};
    tbl[26] = '{1'b0, 7'h00, 32'h0, 4'h0, 32'h1, OK};

    duties[0] = 64;
    duties[1] = 0;
    duties[2] = 255;
    duties[3] = 1;

    // Reset values.
    repeat (3) @(negedge ACLK);
    chk("rst_led", 32'(led_o), 32'h0);
    chk("rst_awready", 32'(S_AXI_AWREADY), 32'h0);
    chk("rst_wready", 32'(S_AXI_WREADY), 32'h0);
    chk("rst_arready", 32'(S_AXI_ARREADY), 32'h0);
    chk("rst_bvalid", 32'(S_AXI_BVALID), 32'h0);
    chk("rst_rvalid", 32'(S_AXI_RVALID), 32'h0);
    chk("rst_bresp", 32'(S_AXI_BRESP), 32'h0);
    chk("rst_rresp", 32'(S_AXI_RRESP), 32'h0);
    chk("rst_rdata", S_AXI_RDATA, 32'h0);
    @(posedge ACLK); #1;
    ARESETN = 1'b1;
    repeat (2) @(posedge ACLK); #1;

    // Register vectors.
    for (int i = 0; i < 27; i++) begin
      if (tbl[i].wr)
        axi_write(tbl[i].addr, tbl[i].data, tbl[i].strb,
                  tbl[i].exp_r, $sformatf("vec%0d", i));
      else
        axi_read(tbl[i].addr, tbl[i].exp_d, tbl[i].exp_r,
                 $sformatf("vec%0d", i));
    end
    chk("vec_led0_on", 32'(led_o), 32'h1);

    // ON latency: not yet at the handshake edge, set one edge later.
    axi_write(7'h10, 32'h0, 4'hF, OK, "lat_off");
    repeat (3) @(posedge ACLK); #1;
    chk("lat_off_led", 32'(led_o[0]), 32'h0);
    axi_write(7'h10, 32'h1, 4'hF, OK, "lat_on");
    chk("lat_hs_edge", 32'(led_snap[0]), 32'h0);
    chk("lat_next_edge", 32'(led_o[0]), 32'h1);

    // Blink with half-period 4 at a tick every cycle.
    axi_write(7'h18, 32'h0004_0002, 4'hF, OK, "blink_cfg");
    prev = led_o[2];
    run = 0; tog = 0; bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge ACLK);
      if (led_o[2] != prev) begin
        if (tog > 0 && run != 4) bad++;
        tog++;
        run = 1;
        prev = led_o[2];
      end else begin
        run++;
      end
    end
    @(posedge ACLK); #1;
    chk("blink_bad_runs", 32'(bad), 32'h0);
    chk("blink_toggles_ge8", 32'(tog >= 8), 32'h1);
    axi_write(7'h00, 32'h0, 4'hF, OK, "en_off");
    chk("en_off_leds", 32'(led_o), 32'h0);
    repeat (6) @(posedge ACLK); #1;
    chk("en_off_hold", 32'(led_o), 32'h0);
    axi_write(7'h00, 32'h1, 4'hF, OK, "en_on");
    axi_write(7'h18, 32'h0, 4'hF, OK, "blink_off");

    // PWM duty: high samples per 256-cycle period.
    for (int d = 0; d < 4; d++) begin
      axi_write(7'h1C, {16'd0, 8'(duties[d]), 8'h03}, 4'hF, OK,
                $sformatf("pwm_cfg%0d", d));
      hi = 0;
      for (int i = 0; i < 256; i++) begin
        @(negedge ACLK);
        if (led_o[3]) hi++;
      end
      @(posedge ACLK); #1;
      chk($sformatf("pwm_high_d%0d", duties[d]), 32'(hi),
          32'(duties[d]));
    end
    axi_write(7'h1C, 32'h0, 4'hF, OK, "pwm_off");

    // Back-pressure: second write waits for B to complete.
    S_AXI_BREADY = 1'b0;
    bq.push_back('{exp_r: OK, tag: "bp1"});
    S_AXI_AWADDR  = 7'h14;
    S_AXI_WDATA   = 32'h1;
    S_AXI_WSTRB   = 4'hF;
    S_AXI_AWVALID = 1'b1;
    S_AXI_WVALID  = 1'b1;
    wait_aw("bp1");
    @(posedge ACLK); #1;
    bq.push_back('{exp_r: OK, tag: "bp2"});
    S_AXI_WDATA = 32'h0;
    seen = 0;
    repeat (10) begin
      @(negedge ACLK);
      if (S_AXI_AWREADY) seen++;
    end
    chk("bp_no_awready", 32'(seen), 32'h0);
    chk("bp_bvalid_held", 32'(S_AXI_BVALID), 32'h1);
    chk("bp_first_landed", 32'(led_o[1]), 32'h1);
    @(posedge ACLK); #1;
    S_AXI_BREADY = 1'b1;
    wait_aw("bp2");
    @(posedge ACLK); #1;
    S_AXI_AWVALID = 1'b0;
    S_AXI_WVALID  = 1'b0;
    wait_empty("bp");
    repeat (2) @(posedge ACLK); #1;
    chk("bp_second_landed", 32'(led_o[1]), 32'h0);

    // Same-cycle read and write: read sees the old value.
    rq.push_back('{exp_d: 32'h0, exp_r: OK, tag: "rw_read"});
    bq.push_back('{exp_r: OK, tag: "rw_write"});
    S_AXI_AWADDR  = 7'h04;
    S_AXI_WDATA   = 32'h7;
    S_AXI_WSTRB   = 4'hF;
    S_AXI_ARADDR  = 7'h04;
    S_AXI_AWVALID = 1'b1;
    S_AXI_WVALID  = 1'b1;
    S_AXI_ARVALID = 1'b1;
    wait_aw("rw");
    chk("rw_arready_same", 32'(S_AXI_ARREADY), 32'h1);
    @(posedge ACLK); #1;
    S_AXI_AWVALID = 1'b0;
    S_AXI_WVALID  = 1'b0;
    S_AXI_ARVALID = 1'b0;
    wait_empty("rw");
    axi_read(7'h04, 32'h7, OK, "rw_after");
    axi_write(7'h04, 32'h0, 4'hF, OK, "pre_zero");

    // Reset while B and R are both pending.
    S_AXI_BREADY  = 1'b0;
    S_AXI_RREADY  = 1'b0;
    S_AXI_AWADDR  = 7'h00;
    S_AXI_WDATA   = 32'h1;
    S_AXI_ARADDR  = 7'h00;
    S_AXI_AWVALID = 1'b1;
    S_AXI_WVALID  = 1'b1;
    S_AXI_ARVALID = 1'b1;
    wait_aw("mid");
    @(posedge ACLK); #1;
    S_AXI_AWVALID = 1'b0;
    S_AXI_WVALID  = 1'b0;
    S_AXI_ARVALID = 1'b0;
    @(negedge ACLK);
    chk("mid_bvalid_pend", 32'(S_AXI_BVALID), 32'h1);
    chk("mid_rvalid_pend", 32'(S_AXI_RVALID), 32'h1);
    #2 ARESETN = 1'b0;
    #1;
    chk("mid_bvalid_drop", 32'(S_AXI_BVALID), 32'h0);
    chk("mid_rvalid_drop", 32'(S_AXI_RVALID), 32'h0);
    chk("mid_led_rst", 32'(led_o), 32'h0);
    S_AXI_BREADY = 1'b1;
    S_AXI_RREADY = 1'b1;
    @(posedge ACLK); #1;
    ARESETN = 1'b1;
    repeat (2) @(posedge ACLK); #1;
    axi_read(7'h00, 32'h0, OK, "post_rst_ctrl");
    axi_read(7'h10, 32'h0, OK, "post_rst_ch0");
    axi_read(7'h0C, 32'h4C43_0008, OK, "post_rst_id");

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
